// File: rtl/btn_event_arbiter.sv
// btn_event_arbiter: debounces N push-buttons and serves their press events round-robin on a valid/ready channel.
// Define BTN_AUTOREPEAT_EN to add per-button auto-repeat while a button is held.
module btn_event_arbiter #(
    parameter int N_BTN      = 4,
    parameter int SAMPLE_DIV = 100000,
    parameter int STABLE_CNT = 4,
    parameter int REPEAT_DLY = 50,
    parameter int REPEAT_PER = 10
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [N_BTN-1:0]         i_btn_in,
    input  logic                     i_evt_ready,
    output logic                     o_evt_valid,
    output logic [$clog2(N_BTN)-1:0] o_evt_id,
    output logic [N_BTN-1:0]         o_btn_level,
    output logic                     o_evt_drop
);
    localparam int IW = $clog2(N_BTN);
    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int CW = $clog2(STABLE_CNT + 1);

    typedef enum logic {S_IDLE, S_PRESENT} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_BTN-1:0] r_sync1, r_sync2, r_level, r_level_d, r_pending;
    logic [N_BTN-1:0] w_set, w_clr, w_rpt_fire;
    logic [CW-1:0]    r_cnt [N_BTN];
    logic [DW-1:0]    r_div;
    logic [IW-1:0]    r_evt_id, r_rr_ptr, w_sel;
    logic             r_drop, w_tick, w_grant, w_accept;

    if (N_BTN < 2 || SAMPLE_DIV < 2 || STABLE_CNT < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
        $error("btn_event_arbiter: parameter out of range");
    end

    function automatic logic [IW-1:0] f_wrap(input int v);
        return IW'(v >= N_BTN ? v - N_BTN : v);
    endfunction

    assign w_tick = (r_div == DW'(SAMPLE_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_div   <= '0;
        end else begin
            r_sync1 <= i_btn_in;
            r_sync2 <= r_sync1;
            r_div   <= w_tick ? '0 : r_div + DW'(1);
        end
    end

    // A level flips only after STABLE_CNT consecutive ticks disagreeing with it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_level   <= '0;
            r_level_d <= '0;
            for (int i = 0; i < N_BTN; i++) r_cnt[i] <= '0;
        end else begin
            r_level_d <= r_level;
            for (int i = 0; i < N_BTN; i++) begin
                if (w_tick) begin
                    if (r_sync2[i] == r_level[i]) begin
                        r_cnt[i] <= '0;
                    end else if (r_cnt[i] == CW'(STABLE_CNT - 1)) begin
                        r_level[i] <= ~r_level[i];
                        r_cnt[i]   <= '0;
                    end else begin
                        r_cnt[i] <= r_cnt[i] + CW'(1);
                    end
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0]    r_rpt [N_BTN];
    logic [N_BTN-1:0] r_armed;

    always_comb begin
        w_rpt_fire = '0;
        for (int i = 0; i < N_BTN; i++)
            w_rpt_fire[i] = w_tick && r_level[i] &&
                            (r_rpt[i] == RW'((r_armed[i] ? REPEAT_PER : REPEAT_DLY) - 1));
    end

    // r_armed marks that the first (long) delay has elapsed; later repeats use the short period
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_armed <= '0;
            for (int i = 0; i < N_BTN; i++) r_rpt[i] <= '0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                if (!r_level[i]) begin
                    r_rpt[i]   <= '0;
                    r_armed[i] <= 1'b0;
                end else if (w_rpt_fire[i]) begin
                    r_rpt[i]   <= '0;
                    r_armed[i] <= 1'b1;
                end else if (w_tick) begin
                    r_rpt[i] <= r_rpt[i] + RW'(1);
                end
            end
        end
    end
`else
    assign w_rpt_fire = '0;
`endif

    assign w_set = (r_level & ~r_level_d) | w_rpt_fire;

    always_comb begin
        w_sel = r_rr_ptr;
        for (int k = N_BTN - 1; k >= 0; k--)
            if (r_pending[f_wrap(int'(r_rr_ptr) + k)]) w_sel = f_wrap(int'(r_rr_ptr) + k);
        w_grant     = (r_state == S_IDLE) && (|r_pending);
        w_accept    = (r_state == S_PRESENT) && i_evt_ready;
        w_clr       = w_grant ? N_BTN'(1) << w_sel : '0;
        w_state_nxt = w_grant ? S_PRESENT : (w_accept ? S_IDLE : r_state);
    end

    // A set arriving alongside the grant clear survives, so it is not counted as a drop
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_drop    <= 1'b0;
            r_evt_id  <= '0;
            r_rr_ptr  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_drop    <= |(w_set & r_pending & ~w_clr);
            if (w_grant) r_evt_id <= w_sel;
            if (w_accept) r_rr_ptr <= f_wrap(int'(r_evt_id) + 1);
        end
    end

    assign o_evt_valid = (r_state == S_PRESENT);
    assign o_evt_id    = r_evt_id;
    assign o_btn_level = r_level;
    assign o_evt_drop  = r_drop;
endmodule

// File: tb/tb_btn_event_arbiter.sv
// tb_btn_event_arbiter: directed scenarios plus random stimulus, each cycle compared to a behavioural model.
module tb_btn_event_arbiter;
    localparam int N = 4, SD = 4, SC = 3, RD = 5, RP = 2;

    logic         clk = 1'b0, rst_n = 1'b1, evt_ready = 1'b1;
    logic [N-1:0] btn_in = '0;
    logic         evt_valid, evt_drop;
    logic [1:0]   evt_id;
    logic [N-1:0] btn_level;

    int checks = 0, errors = 0;
    int dut_ids[$];
    int dut_drops = 0;
    int base, dbase;

    logic [N-1:0] m_s1, m_s2, m_lvl, m_pend, m_press;
    int           m_cnt [N];
    int           m_t [N];
    int           m_div, m_id, m_rr;
    logic         m_busy, m_drop;

    btn_event_arbiter #(
        .N_BTN(N), .SAMPLE_DIV(SD), .STABLE_CNT(SC), .REPEAT_DLY(RD), .REPEAT_PER(RP)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn_in(btn_in), .i_evt_ready(evt_ready),
        .o_evt_valid(evt_valid), .o_evt_id(evt_id), .o_btn_level(btn_level), .o_evt_drop(evt_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_pend = '0; m_press = '0;
        m_div = 0; m_id = 0; m_rr = 0; m_busy = 1'b0; m_drop = 1'b0;
        for (int i = 0; i < N; i++) begin m_cnt[i] = 0; m_t[i] = 0; end
    endtask

    // One clock edge of the specified behaviour, from the pre-edge state and inputs
    task automatic model_step();
        logic         tick, found;
        logic [N-1:0] lvl_old, sets, clr, fire, press_new;
        int           sel;
        tick = (m_div == SD - 1);
        lvl_old = m_lvl; clr = '0; fire = '0; press_new = '0; sel = 0; found = 1'b0;
        m_div = (m_div + 1) % SD;
        for (int i = 0; i < N; i++) begin
            if (tick) begin
                if (m_s2[i] != m_lvl[i]) begin
                    m_cnt[i]++;
                    if (m_cnt[i] == SC) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_cnt[i] = 0;
                        press_new[i] = m_lvl[i];
                    end
                end else m_cnt[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = btn_in;
`ifdef BTN_AUTOREPEAT_EN
        for (int i = 0; i < N; i++) begin
            if (!lvl_old[i]) m_t[i] = 0;
            else if (tick) begin
                m_t[i]++;
                fire[i] = (m_t[i] == RD) || (m_t[i] > RD && (m_t[i] - RD) % RP == 0);
            end
        end
`endif
        sets = m_press | fire;
        m_press = press_new;
        if (!m_busy) begin
            for (int k = 0; k < N; k++)
                if (!found && m_pend[(m_rr + k) % N]) begin sel = (m_rr + k) % N; found = 1'b1; end
            if (found) clr[sel] = 1'b1;
        end
        m_drop = |(sets & m_pend & ~clr);
        m_pend = (m_pend & ~clr) | sets;
        if (found) begin m_busy = 1'b1; m_id = sel; end
        else if (m_busy && evt_ready) begin m_busy = 1'b0; m_rr = (m_id + 1) % N; end
    endtask

    task automatic cycle();
        if (evt_valid && evt_ready) dut_ids.push_back(int'(evt_id));
        if (evt_drop) dut_drops++;
        @(posedge clk);
        if (!rst_n) model_reset(); else model_step();
        #1;
        chk("valid", evt_valid, m_busy);
        if (m_busy) chk("id", evt_id, m_id);
        chk("level", btn_level, m_lvl);
        chk("drop", evt_drop, m_drop);
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    initial begin
        model_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", evt_valid, 0);
        chk("rst_level", btn_level, 0);
        chk("rst_drop", evt_drop, 0);
        run(3);
        rst_n = 1'b1;
        run(5);

        // clean press held for 20 ticks
        base = dut_ids.size();
        btn_in = 4'b0100; run(80); btn_in = '0; run(40);
        chk("t1_first_id", dut_ids[base], 2);
`ifndef BTN_AUTOREPEAT_EN
        chk("t1_events", dut_ids.size() - base, 1);
`endif

        // bounce on button 0, then a clean hold
        base = dut_ids.size();
        for (int t = 0; t < 10; t++) begin
            btn_in[0] = (t % 2 == 0);
            run(4);
            chk("t2_bounce_level", btn_level[0], 0);
        end
        btn_in[0] = 1'b1; run(14); btn_in = '0; run(30);
        chk("t2_events", dut_ids.size() - base, 1);
        chk("t2_id", dut_ids[base], 0);

        // round-robin fairness
        base = dut_ids.size();
        btn_in = 4'b0010; run(14); btn_in = '0; run(30);
        btn_in = 4'b0101; run(14); btn_in = '0; run(30);
        chk("t3_events", dut_ids.size() - base, 3);
        chk("t3_ev0", dut_ids[base], 1);
        chk("t3_ev1", dut_ids[base + 1], 2);
        chk("t3_ev2", dut_ids[base + 2], 0);

        // backpressure and drop
        evt_ready = 1'b0;
        base = dut_ids.size();
        dbase = dut_drops;
        repeat (3) begin btn_in = 4'b0001; run(14); btn_in = '0; run(20); end
        chk("t4_stalled_events", dut_ids.size() - base, 0);
        chk("t4_drops", dut_drops - dbase, 1);
        evt_ready = 1'b1; run(10);
        chk("t4_events", dut_ids.size() - base, 2);
        chk("t4_ev0", dut_ids[base], 0);
        chk("t4_ev1", dut_ids[base + 1], 0);

        // asynchronous reset while presenting
        evt_ready = 1'b0;
        btn_in = 4'b1000;
        for (int c = 0; c < 40 && !evt_valid; c++) cycle();
        chk("t5_valid_pre", evt_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_valid_rst", evt_valid, 0);
        chk("t5_level_rst", btn_level, 0);
        chk("t5_drop_rst", evt_drop, 0);
        model_reset();
        run(3);
        rst_n = 1'b1;
        evt_ready = 1'b1;
        base = dut_ids.size();
        run(40); btn_in = '0; run(30);
        chk("t5_id", dut_ids[base], 3);
`ifndef BTN_AUTOREPEAT_EN
        chk("t5_events", dut_ids.size() - base, 1);
`endif

        // hold for 11 ticks after the level rises
        btn_in = 4'b0010;
        for (int c = 0; c < 40 && !btn_level[1]; c++) cycle();
        chk("t6_level_rise", btn_level[1], 1);
        base = dut_ids.size();
        run(44); btn_in = '0; run(4);
`ifdef BTN_AUTOREPEAT_EN
        chk("t6_events", dut_ids.size() - base, 5);
`else
        chk("t6_events", dut_ids.size() - base, 1);
`endif
        run(60);

        // random stimulus against the model
        for (int r = 0; r < 60; r++) begin
            btn_in = N'($urandom_range(0, 15));
            evt_ready = ($urandom_range(0, 3) != 0);
            run($urandom_range(1, 30));
        end
        btn_in = '0;
        evt_ready = 1'b1;
        run(100);
        chk("final_idle", evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
